axis_frame_gen: RTL and testbench

- Single-clock AXI-stream frame transmitter. Produces configurable frames with an incrementing data pattern.
- Used as the traffic source that drives the input side of the team's AXI-stream FIFOs in system-level and loopback tests.
- Supports frame length, frame count, inter-frame gap and graceful stop.

---
 rtl/axis_frame_gen_pkg.sv | 13 +
 rtl/axis_frame_gen.sv | 214 +++++++++++++++++++++
 tb/tb_axis_frame_gen.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_gen_pkg.sv
// Shared types and default widths for the AXI-stream frame generator.
package axis_frame_gen_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int LEN_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

endpackage : axis_frame_gen_pkg

// File: rtl/axis_frame_gen.sv
// AXI-stream frame generator: emits num_frames frames of frame_len beats with an
// incrementing data pattern, gap_cycles idle cycles between frames, and a graceful stop.
// Optional build macro AXIS_FRAME_GEN_ERR_INJ_EN: mark the tlast beat of frame err_frame
// with tuser=1. Without it tuser is constant 0 and err_frame is ignored.
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [LEN_WIDTH-1:0]  num_frames,
    input  logic [LEN_WIDTH-1:0]  gap_cycles,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [LEN_WIDTH-1:0]  err_frame,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  frames_sent
);

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [LEN_WIDTH-1:0]  gap_q, gap_d;
    logic [LEN_WIDTH-1:0]  frames_sent_q, frames_sent_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  num_q, num_d;
    logic [LEN_WIDTH-1:0]  gap_len_q, gap_len_d;
    logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
    logic                  stop_pend_q, stop_pend_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  tuser_q, tuser_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  handshake;
    logic                  end_run;
    logic [LEN_WIDTH-1:0]  frames_inc;

`ifdef AXIS_FRAME_GEN_ERR_INJ_EN
    logic [LEN_WIDTH-1:0]  err_q, err_d;
`else
    logic                  unused_err;
    assign unused_err = ^err_frame;
`endif

    assign handshake  = tvalid_q & output_axis_tready;
    assign frames_inc = frames_sent_q + LEN_ONE;

    // State register: FSM, counters, latched config and registered outputs.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            gap_q         <= '0;
            frames_sent_q <= '0;
            len_q         <= '0;
            num_q         <= '0;
            gap_len_q     <= '0;
            pattern_q     <= '0;
            stop_pend_q   <= 1'b0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tuser_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef AXIS_FRAME_GEN_ERR_INJ_EN
            err_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            gap_q         <= gap_d;
            frames_sent_q <= frames_sent_d;
            len_q         <= len_d;
            num_q         <= num_d;
            gap_len_q     <= gap_len_d;
            pattern_q     <= pattern_d;
            stop_pend_q   <= stop_pend_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            tuser_q       <= tuser_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef AXIS_FRAME_GEN_ERR_INJ_EN
            err_q         <= err_d;
`endif
        end
    end

    // Next-state logic: run control, beat/gap/frame counters and next output values.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d       = state_q;
        beat_d        = beat_q;
        gap_d         = gap_q;
        frames_sent_d = frames_sent_q;
        len_d         = len_q;
        num_d         = num_q;
        gap_len_d     = gap_len_q;
        pattern_d     = pattern_q;
        stop_pend_d   = stop_pend_q;
        tvalid_d      = tvalid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        end_run       = 1'b0;
`ifdef AXIS_FRAME_GEN_ERR_INJ_EN
        err_d         = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    frames_sent_d = '0;
                    if ((frame_len == '0) || (num_frames == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        len_d       = frame_len;
                        num_d       = num_frames;
                        gap_len_d   = gap_cycles;
                        pattern_d   = seed;
                        beat_d      = '0;
                        stop_pend_d = 1'b0;
                        busy_d      = 1'b1;
                        tvalid_d    = 1'b1;
                        state_d     = SEND;
`ifdef AXIS_FRAME_GEN_ERR_INJ_EN
                        err_d       = err_frame;
`endif
                    end
                end
            end

            SEND: begin
                stop_pend_d = stop_pend_q | stop;
                if (handshake) begin
                    pattern_d = pattern_q + DATA_ONE;
                    if (tlast_q) begin
                        frames_sent_d = frames_inc;
                        beat_d        = '0;
                        // A stop arriving with the last beat still only ends the run here.
                        if ((frames_inc == num_q) || stop_pend_q || stop) begin
                            end_run = 1'b1;
                        end else if (gap_len_q != '0) begin
                            state_d  = GAP;
                            gap_d    = '0;
                            tvalid_d = 1'b0;
                        end
                    end else begin
                        beat_d = beat_q + LEN_ONE;
                    end
                end
            end

            GAP: begin
                stop_pend_d = stop_pend_q | stop;
                if (gap_q == (gap_len_q - LEN_ONE)) begin
                    if (stop_pend_q || stop) begin
                        end_run = 1'b1;
                    end else begin
                        state_d  = SEND;
                        tvalid_d = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + LEN_ONE;
                end
            end

            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase

        if (end_run) begin
            state_d     = IDLE;
            tvalid_d    = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
        end

        // Sidebands derive from the next beat, so they stay stable through a stall.
        tlast_d = tvalid_d && (beat_d == (len_d - LEN_ONE));
`ifdef AXIS_FRAME_GEN_ERR_INJ_EN
        tuser_d = tlast_d && (frames_sent_d == err_d);
`else
        tuser_d = 1'b0;
`endif
    end

    assign output_axis_tdata  = pattern_q;
    assign output_axis_tvalid = tvalid_q;
    assign output_axis_tlast  = tlast_q;
    assign output_axis_tuser  = tuser_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign frames_sent        = frames_sent_q;

endmodule : axis_frame_gen

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen (default widths). Build with
// AXIS_FRAME_GEN_ERR_INJ_EN defined to expect the error-injection marking.
module tb_axis_frame_gen;

    logic        clk;
    logic        async_rst_n;
    logic        start;
    logic        stop;
    logic [15:0] frame_len;
    logic [15:0] num_frames;
    logic [15:0] gap_cycles;
    logic [7:0]  seed;
    logic [15:0] err_frame;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;
    logic        busy;
    logic        done;
    logic [15:0] frames_sent;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-cycle snapshot of the DUT, taken on the falling edge.
    logic [7:0]  d_a  [64];
    logic        v_a  [64];
    logic        l_a  [64];
    logic        u_a  [64];
    logic        dn_a [64];
    logic        bz_a [64];
    logic        r_a  [64];

    axis_frame_gen dut (
        .clk                (clk),
        .async_rst_n        (async_rst_n),
        .start              (start),
        .stop               (stop),
        .frame_len          (frame_len),
        .num_frames         (num_frames),
        .gap_cycles         (gap_cycles),
        .seed               (seed),
        .err_frame          (err_frame),
        .output_axis_tdata  (tdata),
        .output_axis_tvalid (tvalid),
        .output_axis_tready (tready),
        .output_axis_tlast  (tlast),
        .output_axis_tuser  (tuser),
        .busy               (busy),
        .done               (done),
        .frames_sent        (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle start pulse with a given configuration; returns on the first run cycle.
    task automatic do_start(input logic [15:0] len, input logic [15:0] num,
                            input logic [15:0] gap, input logic [7:0] sd,
                            input logic [15:0] err);
        @(negedge clk);
        frame_len  = len;
        num_frames = num;
        gap_cycles = gap;
        seed       = sd;
        err_frame  = err;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Record n cycles; rdy_mode 0 = always ready, 1 = ready on even cycles only.
    task automatic capture(input int n, input int rdy_mode, input int stop_cyc);
        for (int c = 0; c < n; c++) begin
            tready  = (rdy_mode == 0) ? 1'b1 : ((c % 2) == 0);
            stop    = (c == stop_cyc);
            v_a[c]  = tvalid;
            d_a[c]  = tdata;
            l_a[c]  = tlast;
            u_a[c]  = tuser;
            dn_a[c] = done;
            bz_a[c] = busy;
            r_a[c]  = tready;
            @(negedge clk);
        end
        tready = 1'b1;
        stop   = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({tvalid, tlast, tuser, busy, done, tdata, frames_sent} !== 28'h0) begin
            n_bad++;
            $display("FAIL reset_hold outputs got %h want 0",
                     {tvalid, tlast, tuser, busy, done, tdata, frames_sent});
        end
        async_rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({tvalid, busy, done, frames_sent} !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_idle outputs got %h want 0", {tvalid, busy, done, frames_sent});
        end
    endtask

    task automatic test_single_frame();
        do_start(16'd4, 16'd1, 16'd0, 8'h10, 16'hFFFF);
        capture(10, 0, -1);
        for (int c = 0; c < 10; c++) begin
            logic [7:0] ed;
            ed = 8'h10 + 8'(c);
            n_cmp++;
            if (v_a[c] !== (c < 4)) begin
                n_bad++;
                $display("FAIL single_valid c%0d got %0b want %0b", c, v_a[c], (c < 4));
            end
            if (c < 4) begin
                n_cmp++;
                if (d_a[c] !== ed || l_a[c] !== (c == 3) || u_a[c] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL single_beat c%0d got d=%h l=%0b u=%0b want d=%h l=%0b u=0",
                             c, d_a[c], l_a[c], u_a[c], ed, (c == 3));
                end
            end
            n_cmp++;
            if (dn_a[c] !== (c == 4) || bz_a[c] !== (c < 4)) begin
                n_bad++;
                $display("FAIL single_ctl c%0d got done=%0b busy=%0b want done=%0b busy=%0b",
                         c, dn_a[c], bz_a[c], (c == 4), (c < 4));
            end
        end
        n_cmp++;
        if (frames_sent !== 16'd1) begin
            n_bad++;
            $display("FAIL single_frames_sent got %0d want 1", frames_sent);
        end
    endtask

    task automatic test_gap_wrap();
        logic [7:0] ed [8];
        logic       ev [10];
        ed = '{8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
        ev = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_start(16'd3, 16'd2, 16'd2, 8'hFE, 16'hFFFF);
        capture(10, 0, -1);
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (v_a[c] !== ev[c]) begin
                n_bad++;
                $display("FAIL gap_valid c%0d got %0b want %0b", c, v_a[c], ev[c]);
            end
            if (c < 8 && ev[c]) begin
                n_cmp++;
                if (d_a[c] !== ed[c] || l_a[c] !== (c == 2 || c == 7)) begin
                    n_bad++;
                    $display("FAIL gap_beat c%0d got d=%h l=%0b want d=%h l=%0b",
                             c, d_a[c], l_a[c], ed[c], (c == 2 || c == 7));
                end
            end
            n_cmp++;
            if (dn_a[c] !== (c == 8) || bz_a[c] !== (c < 8)) begin
                n_bad++;
                $display("FAIL gap_ctl c%0d got done=%0b busy=%0b want done=%0b busy=%0b",
                         c, dn_a[c], bz_a[c], (c == 8), (c < 8));
            end
        end
        n_cmp++;
        if (frames_sent !== 16'd2) begin
            n_bad++;
            $display("FAIL gap_frames_sent got %0d want 2", frames_sent);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] ed [7];
        int         hs;
        ed = '{8'h20, 8'h21, 8'h21, 8'h22, 8'h22, 8'h23, 8'h23};
        hs = 0;
        do_start(16'd4, 16'd1, 16'd0, 8'h20, 16'hFFFF);
        capture(10, 1, -1);
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (v_a[c] !== (c < 7)) begin
                n_bad++;
                $display("FAIL bp_valid c%0d got %0b want %0b", c, v_a[c], (c < 7));
            end
            if (c < 7) begin
                n_cmp++;
                if (d_a[c] !== ed[c] || l_a[c] !== (c >= 5)) begin
                    n_bad++;
                    $display("FAIL bp_beat c%0d got d=%h l=%0b want d=%h l=%0b",
                             c, d_a[c], l_a[c], ed[c], (c >= 5));
                end
            end
            if (v_a[c] && r_a[c]) hs++;
            n_cmp++;
            if (dn_a[c] !== (c == 7)) begin
                n_bad++;
                $display("FAIL bp_done c%0d got %0b want %0b", c, dn_a[c], (c == 7));
            end
        end
        n_cmp++;
        if (hs != 4) begin
            n_bad++;
            $display("FAIL bp_handshakes got %0d want 4", hs);
        end
    endtask

    task automatic test_stop_back_to_back();
        do_start(16'd4, 16'd5, 16'd0, 8'h40, 16'hFFFF);
        capture(16, 0, 5);
        for (int c = 0; c < 16; c++) begin
            logic [7:0] ed;
            ed = 8'h40 + 8'(c);
            n_cmp++;
            if (v_a[c] !== (c < 8)) begin
                n_bad++;
                $display("FAIL stop_valid c%0d got %0b want %0b", c, v_a[c], (c < 8));
            end
            if (c < 8) begin
                n_cmp++;
                if (d_a[c] !== ed || l_a[c] !== (c == 3 || c == 7)) begin
                    n_bad++;
                    $display("FAIL stop_beat c%0d got d=%h l=%0b want d=%h l=%0b",
                             c, d_a[c], l_a[c], ed, (c == 3 || c == 7));
                end
            end
            n_cmp++;
            if (dn_a[c] !== (c == 8) || bz_a[c] !== (c < 8)) begin
                n_bad++;
                $display("FAIL stop_ctl c%0d got done=%0b busy=%0b want done=%0b busy=%0b",
                         c, dn_a[c], bz_a[c], (c == 8), (c < 8));
            end
        end
        n_cmp++;
        if (frames_sent !== 16'd2) begin
            n_bad++;
            $display("FAIL stop_frames_sent got %0d want 2", frames_sent);
        end
    endtask

    task automatic test_zero_config();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) do_start(16'd0, 16'd3, 16'd0, 8'h00, 16'hFFFF);
            else        do_start(16'd4, 16'd0, 16'd0, 8'h00, 16'hFFFF);
            capture(3, 0, -1);
            for (int c = 0; c < 3; c++) begin
                n_cmp++;
                if (v_a[c] !== 1'b0 || bz_a[c] !== 1'b0 || dn_a[c] !== (c == 0)) begin
                    n_bad++;
                    $display("FAIL zero%0d c%0d got v=%0b busy=%0b done=%0b want v=0 busy=0 done=%0b",
                             k, c, v_a[c], bz_a[c], dn_a[c], (c == 0));
                end
            end
            n_cmp++;
            if (frames_sent !== 16'd0) begin
                n_bad++;
                $display("FAIL zero%0d_frames_sent got %0d want 0", k, frames_sent);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_start(16'd10, 16'd1, 16'd0, 8'h55, 16'hFFFF);
        capture(3, 0, -1);
        n_cmp++;
        if (v_a[2] !== 1'b1 || d_a[2] !== 8'h57) begin
            n_bad++;
            $display("FAIL rst_pre got v=%0b d=%h want v=1 d=57", v_a[2], d_a[2]);
        end
        #2 async_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tvalid, tlast, busy, done, tdata, frames_sent} !== 27'h0) begin
            n_bad++;
            $display("FAIL rst_mid outputs got v=%0b l=%0b busy=%0b done=%0b d=%h fs=%0d want all 0",
                     tvalid, tlast, busy, done, tdata, frames_sent);
        end
        @(negedge clk);
        async_rst_n = 1'b1;
        capture(3, 0, -1);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (v_a[c] !== 1'b0 || bz_a[c] !== 1'b0 || dn_a[c] !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_after c%0d got v=%0b busy=%0b done=%0b want 0 0 0",
                         c, v_a[c], bz_a[c], dn_a[c]);
            end
        end
    endtask

    task automatic test_err_inj();
        logic [7:0] ed [8];
        logic       ev [8];
        logic       eu;
        ed = '{8'h80, 8'h81, 8'h00, 8'h82, 8'h83, 8'h00, 8'h84, 8'h85};
        ev = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        do_start(16'd2, 16'd3, 16'd1, 8'h80, 16'd1);
        capture(10, 0, -1);
        for (int c = 0; c < 10; c++) begin
`ifdef AXIS_FRAME_GEN_ERR_INJ_EN
            eu = (c == 4);
`else
            eu = 1'b0;
`endif
            n_cmp++;
            if (u_a[c] !== eu) begin
                n_bad++;
                $display("FAIL err_tuser c%0d got %0b want %0b", c, u_a[c], eu);
            end
            if (c < 8) begin
                n_cmp++;
                if (v_a[c] !== ev[c] || (ev[c] && d_a[c] !== ed[c])) begin
                    n_bad++;
                    $display("FAIL err_beat c%0d got v=%0b d=%h want v=%0b d=%h",
                             c, v_a[c], d_a[c], ev[c], ed[c]);
                end
            end
        end
        n_cmp++;
        if (frames_sent !== 16'd3) begin
            n_bad++;
            $display("FAIL err_frames_sent got %0d want 3", frames_sent);
        end
    endtask

    initial begin
        async_rst_n = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        tready      = 1'b1;
        frame_len   = '0;
        num_frames  = '0;
        gap_cycles  = '0;
        seed        = '0;
        err_frame   = 16'hFFFF;
        test_reset();
        test_single_frame();
        test_gap_wrap();
        test_backpressure();
        test_stop_back_to_back();
        test_zero_config();
        test_err_inj();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_axis_frame_gen
